// File: rtl/tug_key_conditioner_if.sv
// Key/enable/pulse bundle between the tug-of-war key conditioner and its users.
// The master drives the keys and Enable; the slave (the conditioner) drives the pulses and held levels.
interface tug_key_conditioner_if;
  logic KEY_L_n;
  logic KEY_R_n;
  logic Enable;
  logic L;
  logic R;
  logic L_held;
  logic R_held;

  modport master (
    output KEY_L_n, KEY_R_n, Enable,
    input  L, R, L_held, R_held
  );

  modport slave (
    input  KEY_L_n, KEY_R_n, Enable,
    output L, R, L_held, R_held
  );
endinterface

// File: rtl/tug_key_conditioner.sv
// Synchronise, debounce and one-shot the two tug-of-war keys into single-cycle L/R pulses.
// Optional macro TUG_TIE_CANCEL_EN: presses accepted on both keys in the same cycle cancel each other.
module tug_key_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  tug_key_conditioner_if.slave  keys
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0] raw_n;
  logic [1:0] strobe;
  logic [1:0] held;
  logic       tie;

  // Index 0 is the left key, index 1 the right key.
  assign raw_n = {keys.KEY_R_n, keys.KEY_L_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_n;
    logic [1:0]             state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   s;
    logic                   strobe_q, strobe_nxt;
    logic                   held_q;

    // Synchroniser keeps the raw active-low polarity so reset loads "released".
    // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
    always_ff @(posedge Clock) begin
      if (!Reset) sync_n <= '1;
      else        sync_n <= {sync_n[SYNC_STAGES-2:0], raw_n[k]};
    end

    assign s = ~sync_n[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      strobe_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt  = PRESSED;
            cnt_nxt    = '0;
            strobe_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // held_q lags the state by one cycle so it rises together with the output pulse.
    always_ff @(posedge Clock) begin
      if (!Reset) begin
        state    <= IDLE;
        cnt      <= '0;
        strobe_q <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        strobe_q <= strobe_nxt;
        held_q   <= (state == PRESSED) || (state == RELEASE_WAIT);
      end
    end

    assign strobe[k] = strobe_q;
    assign held[k]   = held_q;
  end

`ifdef TUG_TIE_CANCEL_EN
  assign tie = strobe[0] & strobe[1];
`else
  assign tie = 1'b0;
`endif

  // Strobes arriving while disabled are dropped, never queued.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      keys.L <= 1'b0;
      keys.R <= 1'b0;
    end else begin
      keys.L <= strobe[0] & keys.Enable & ~tie;
      keys.R <= strobe[1] & keys.Enable & ~tie;
    end
  end

  assign keys.L_held = held[0];
  assign keys.R_held = held[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Directed bench for tug_key_conditioner at default parameters; pulse edges are hand-derived
// from latency = SYNC_STAGES + DEBOUNCE_CYCLES + 1 = 7 edges after the key is first sampled low.
module tb_tug_key_conditioner;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  tug_key_conditioner_if bus ();

  tug_key_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .keys  (bus.slave)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int l_cnt, r_cnt, both_cnt, l_last, r_last;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    l_cnt = 0; r_cnt = 0; both_cnt = 0; l_last = -1; r_last = -1;
  endtask

  // One clock edge, then sample outputs 1 time unit later and tally pulses.
  task automatic step();
    @(posedge Clock);
    cyc++;
    #1;
    if (bus.L === 1'b1) begin l_cnt++; l_last = cyc; end
    if (bus.R === 1'b1) begin r_cnt++; r_last = cyc; end
    if (bus.L === 1'b1 && bus.R === 1'b1) both_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int outs();
    return int'({bus.L, bus.R, bus.L_held, bus.R_held});
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout reached at edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e, f, held_drop;
    bus.KEY_L_n = 1'b1;
    bus.KEY_R_n = 1'b1;
    bus.Enable  = 1'b1;
    clr();

    // Reset held two edges, then ten idle cycles.
    Reset = 1'b0;
    steps(2);
    check("reset_outs", outs(), 0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outs", outs(), 0);
    end

    // Clean left press held for 20 cycles.
    clr();
    bus.KEY_L_n = 1'b0;
    e = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cyc == e + 6) check("l_held_before", int'(bus.L_held), 0);
      if (cyc == e + 7) check("l_held_rise", int'(bus.L_held), 1);
    end
    check("l_press_count", l_cnt, 1);
    check("l_press_edge", l_last, e + 7);
    check("l_press_no_r", r_cnt, 0);
    bus.KEY_L_n = 1'b1;
    steps(10);
    check("l_release_held", int'(bus.L_held), 0);

    // Right key bounces 0,1,0,1 then steady low from edge e+4.
    clr();
    e = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      bus.KEY_R_n = (i < 4) ? logic'(i % 2) : 1'b0;
      step();
    end
    check("r_bounce_count", r_cnt, 1);
    check("r_bounce_edge", r_last, e + 4 + 7);
    check("r_bounce_no_l", l_cnt, 0);

    // Release bounces 1,0,1,0 then steady high from edge f; held drops after f+7.
    held_drop = 0;
    for (int i = 0; i < 4; i++) begin
      bus.KEY_R_n = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      if (bus.R_held !== 1'b1) held_drop++;
    end
    bus.KEY_R_n = 1'b1;
    f = cyc + 1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.R_held !== 1'b1) held_drop++;
    end
    check("r_held_through_release", held_drop, 0);
    check("r_held_edge_f6", cyc, f + 6);
    step();
    check("r_held_fall", int'(bus.R_held), 0);
    check("r_release_no_pulse", r_cnt, 1);
    steps(4);

    // Both keys pressed before the same edge.
    clr();
    bus.KEY_L_n = 1'b0;
    bus.KEY_R_n = 1'b0;
    e = cyc + 1;
    steps(30);
`ifdef TUG_TIE_CANCEL_EN
    check("tie_l_count", l_cnt, 0);
    check("tie_r_count", r_cnt, 0);
`else
    check("tie_both_count", both_cnt, 1);
    check("tie_l_edge", l_last, e + 7);
    check("tie_r_edge", r_last, e + 7);
`endif
    check("tie_held", int'({bus.L_held, bus.R_held}), 3);
    bus.KEY_L_n = 1'b1;
    bus.KEY_R_n = 1'b1;
    steps(10);

    // Press while disabled, enable while held, then release and re-press.
    clr();
    bus.Enable  = 1'b0;
    bus.KEY_L_n = 1'b0;
    steps(10);
    bus.Enable = 1'b1;
    steps(10);
    check("en_dropped", l_cnt, 0);
    check("en_held", int'(bus.L_held), 1);
    bus.KEY_L_n = 1'b1;
    f = cyc + 1;
    steps(6);
    bus.KEY_L_n = 1'b0;
    steps(20);
    check("en_repress_count", l_cnt, 1);
    check("en_repress_edge", l_last, f + 13);
    bus.KEY_L_n = 1'b1;
    steps(10);

    // Reset mid-debounce at edge e+5, released at e+6, key still held.
    clr();
    bus.KEY_L_n = 1'b0;
    e = cyc + 1;
    steps(5);
    Reset = 1'b0;
    step();
    check("mid_reset_outs", outs(), 0);
    Reset = 1'b1;
    steps(15);
    check("mid_reset_count", l_cnt, 1);
    check("mid_reset_edge", l_last, e + 13);
    bus.KEY_L_n = 1'b1;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_key_conditioner.md
Name: tug_key_conditioner

Overview:
- Input stage that feeds the tug-of-war light chain.
- Takes the two raw, active-low, asynchronous push-button keys (left player, right player).
- Produces the clean single-cycle L and R press pulses consumed by every playfield light cell.
- Per key: synchronise, debounce, one-shot on press; then apply a global enable and a simultaneous-press rule.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per key; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; legal range 1..2^20. Board builds override it to 50000 at 50 MHz.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset. The block is held in reset while Reset==0 at a rising edge of Clock.
- KEY_L_n  input  1  raw left key, 0 = pressed, asynchronous to Clock.
- KEY_R_n  input  1  raw right key, 0 = pressed, asynchronous to Clock.
- Enable  input  1  1 = game running; 0 = pulses suppressed (game over / paused).
- L  output  1  registered one-cycle pulse for an accepted left press.
- R  output  1  registered one-cycle pulse for an accepted right press.
- L_held  output  1  debounced left level, 1 while the key is accepted as pressed.
- R_held  output  1  debounced right level.

Behaviour:
- Reset (Reset==0 at an edge):
  - All synchronizer flops load 1 (released).
  - Both key FSMs go to IDLE and both counters to 0.
  - L, R, L_held, R_held are all 0.
  - Reset mid-debounce discards the partial count.
  - A key still held low when Reset returns to 1 is treated as a new press and produces one pulse after the normal latency.
- Synchronizer: p = ~KEY_x_n passed through SYNC_STAGES flops; the last flop is the sampled level s.
- Per-key FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: if s==1, go to PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT: if s==0, go to IDLE with cnt=0 (bounce rejected). Else if cnt==DEBOUNCE_CYCLES, go to PRESSED and raise the internal press strobe for one cycle. Else cnt+1.
  - PRESSED: if s==0, go to RELEASE_WAIT with cnt=1; otherwise stay. No further strobes while held (no auto-repeat).
  - RELEASE_WAIT: if s==1, go to PRESSED with cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to IDLE. Else cnt+1.
  - DEBOUNCE_CYCLES==1: the first sampled 1 moves to PRESS_WAIT and the next sampled 1 is accepted.
- x_held is 1 in PRESSED and RELEASE_WAIT, 0 otherwise; it is registered and follows the state.
- Output stage (registered):
  - L <= strobeL & Enable & ~tie; R <= strobeR & Enable & ~tie.
  - tie is defined under Optional Feature; when the feature is out, tie = 0.
- Latency: raw key first low before edge 0 and held clean gives L==1 during exactly one cycle, beginning after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults that is edge 7.
- Enable==0:
  - FSMs and held outputs keep running.
  - Strobes in that cycle are dropped, not deferred.
  - Re-enabling while a key is held gives no pulse until the key is released and pressed again.
- Strobes in different cycles for L and R are independent; both can occur in consecutive cycles.
- Counters saturate logically via the FSM and never wrap.

Optional Feature:
- Macro TUG_TIE_CANCEL_EN.
- Defined:
  - tie = strobeL & strobeR.
  - Accepted presses on both keys in the same cycle cancel; neither L nor R pulses.
  - Both FSMs still advance to PRESSED, so holding both keys yields no later pulse.
- Not defined: tie = 0, and simultaneous strobes produce L and R both high in the same cycle.

Test Plan:
- Reset=0 for 2 edges with KEY_L_n=KEY_R_n=1, then Reset=1 for 10 edges -> L=R=L_held=R_held=0 throughout.
- KEY_L_n=0 before edge 0 and held 20 cycles (defaults) -> L=1 only in the cycle after edge 7; L_held=1 from the same cycle; R stays 0; no second pulse.
- KEY_R_n bounces 0,1,0,1 on alternate cycles, then is steady 0 -> no R pulse during bounce; exactly one R pulse 7 edges after the steady-low start. Release bouncing for 3 cycles -> R_held stays 1 until 4 stable released samples.
- Both keys go low before the same edge:
  - with TUG_TIE_CANCEL_EN -> L=R=0 for 30 cycles, L_held=R_held=1;
  - without -> L=R=1 in the same single cycle.
- Enable=0, press L (pulse cycle falls inside the disabled window), set Enable=1 while L is held -> no L pulse; release for 6 cycles and re-press -> one L pulse.
- Press L, drive Reset=0 at edge 5 (mid-debounce), Reset=1 at edge 6, key still held -> no pulse before reset; one pulse after edge 6+7=13.
